// File: rtl/quad_decoder_if.sv
// ============================================================================
//  Module  : quad_decoder_if
//  Purpose : Encoder pins in, up/down counter controls out, for quad_decoder.
//            Index is present only when QDEC_INDEX_EN is defined.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface quad_decoder_if;
    logic A;
    logic B;
`ifdef QDEC_INDEX_EN
    logic Index;
`endif
    logic CountEn;
    logic DownEn;
    logic SClear;
    logic Error;

`ifdef QDEC_INDEX_EN
    modport master (output A, B, Index, input CountEn, DownEn, SClear, Error);
    modport slave  (input A, B, Index, output CountEn, DownEn, SClear, Error);
`else
    modport master (output A, B, input CountEn, DownEn, SClear, Error);
    modport slave  (input A, B, output CountEn, DownEn, SClear, Error);
`endif
endinterface

`default_nettype wire

// File: rtl/quad_decoder.sv
// ============================================================================
//  Module  : quad_decoder
//  Purpose : Synchronised, glitch-filtered x4 quadrature decoder driving an
//            up/down counter. Optional Index/SClear path: QDEC_INDEX_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module quad_decoder #(
    parameter int sync_stages = 2,
    parameter int filt_len    = 4
) (
    input  wire logic      Clock,
    input  wire logic      Reset,
    quad_decoder_if.slave  qd
);

`ifdef QDEC_INDEX_EN
    localparam int c_n = 3;
`else
    localparam int c_n = 2;
`endif
    localparam int c_cnt_w  = (filt_len > 1) ? $clog2(filt_len) : 1;
    localparam int c_init_w = $clog2(sync_stages + 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_max   = c_cnt_w'(filt_len - 1);
    localparam logic [c_init_w-1:0] c_init_last = c_init_w'(sync_stages);

    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [c_init_w-1:0] r_init_cnt;

    logic [c_n-1:0] w_pin;
    logic [c_n-1:0] w_filt;
    logic [c_n-1:0] w_prev;

    assign w_pin[0] = qd.A;
    assign w_pin[1] = qd.B;
`ifdef QDEC_INDEX_EN
    assign w_pin[2] = qd.Index;
`endif

    // Channel 0 = A, 1 = B, 2 = Index; each gets its own sync chain and filter.
    for (genvar i = 0; i < c_n; i++) begin : g_chan
        logic [sync_stages-1:0] r_sync;
        logic [c_cnt_w-1:0]     r_cnt;
        logic                   r_filt;
        logic                   r_prev;
        logic                   w_s;

        assign w_s       = r_sync[sync_stages-1];
        assign w_filt[i] = r_filt;
        assign w_prev[i] = r_prev;

        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                r_sync <= '0;
                r_cnt  <= '0;
                r_filt <= 1'b0;
                r_prev <= 1'b0;
            end else begin
                r_sync <= {r_sync[sync_stages-2:0], w_pin[i]};
                if (r_state == c_st_init) begin
                    // Track the pins directly so release with pins high is not a step.
                    r_filt <= w_s;
                    r_prev <= w_s;
                    r_cnt  <= '0;
                end else begin
                    r_prev <= r_filt;
                    if (w_s == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_max) begin
                        r_filt <= w_s;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state    <= c_st_init;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= (r_state == c_st_init) ? r_init_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_st_init && r_init_cnt == c_init_last) begin
            w_state_nxt = c_st_run;
        end
    end

    logic       r_count_en;
    logic       r_down_en;
    logic       r_error;
    logic       w_count_en_nxt;
    logic       w_down_en_nxt;
    logic       w_error_nxt;
    logic [3:0] w_trans;

    assign w_trans = {w_prev[0], w_prev[1], w_filt[0], w_filt[1]};

    always_comb begin
        w_count_en_nxt = 1'b0;
        w_down_en_nxt  = r_down_en;
        w_error_nxt    = 1'b0;
        if (r_state == c_st_run) begin
            case (w_trans)
                4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                    w_count_en_nxt = 1'b1;
                    w_down_en_nxt  = 1'b0;
                end
                4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                    w_count_en_nxt = 1'b1;
                    w_down_en_nxt  = 1'b1;
                end
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: begin
                    w_error_nxt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_count_en <= 1'b0;
            r_down_en  <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_count_en <= w_count_en_nxt;
            r_down_en  <= w_down_en_nxt;
            r_error    <= w_error_nxt;
        end
    end

    assign qd.CountEn = r_count_en;
    assign qd.DownEn  = r_down_en;
    assign qd.Error   = r_error;

`ifdef QDEC_INDEX_EN
    logic r_sclear;
    logic w_sclear_nxt;

    assign w_sclear_nxt = (r_state == c_st_run) && w_filt[2] && !w_prev[2];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_sclear <= 1'b0;
        end else begin
            r_sclear <= w_sclear_nxt;
        end
    end

    assign qd.SClear = r_sclear;
`else
    assign qd.SClear = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
// ============================================================================
//  Module  : tb_quad_decoder
//  Purpose : Self-checking bench for quad_decoder: directed scenarios plus
//            random pin activity against a sample-window reference model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_quad_decoder;
    localparam int SYNC = 2;
    localparam int FILT = 4;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    quad_decoder_if qd ();

    quad_decoder #(.sync_stages(SYNC), .filt_len(FILT)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .qd    (qd.slave)
    );

`ifdef QDEC_INDEX_EN
    localparam logic [2:0] PMASK = 3'b111;
`else
    localparam logic [2:0] PMASK = 3'b011;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Model: pin history as seen at each rising edge, filtered and previous levels.
    logic [2:0] hist [64];
    int         n;
    logic [2:0] mf, mp;
    logic       e_ce, e_dn, e_err, e_sc;
    int         cnt_ce, cnt_err, cnt_sc, tick_no, first_ce, first_sc;

    // Forward order of {B,A} codes: 00, A, AB, B.
    function automatic int phase(input logic [1:0] v);
        int ord [4] = '{0, 1, 3, 2};
        for (int i = 0; i < 4; i++) if (ord[i] == int'(v)) return i;
        return 0;
    endfunction

    task automatic model_reset(input logic [2:0] p);
        for (int i = 0; i < 64; i++) hist[i] = p;
        n = 64;
        mf = p; mp = p;
        e_ce = 0; e_dn = 0; e_err = 0; e_sc = 0;
    endtask

    task automatic clr_stats();
        cnt_ce = 0; cnt_err = 0; cnt_sc = 0; tick_no = 0; first_ce = -1; first_sc = -1;
    endtask

    task automatic drive(input logic [2:0] p);
        qd.A = p[0];
        qd.B = p[1];
`ifdef QDEC_INDEX_EN
        qd.Index = p[2];
`endif
    endtask

    task automatic tick(input logic [2:0] pin);
        logic [2:0] p;
        int d;
        bit all_diff;
        p = pin & PMASK;
        drive(p);
        @(posedge Clock);
        n++;
        hist[n % 64] = p;
        d = (phase(mf[1:0]) - phase(mp[1:0]) + 4) % 4;
        e_ce  = (d == 1) || (d == 3);
        if (d == 1) e_dn = 1'b0;
        if (d == 3) e_dn = 1'b1;
        e_err = (d == 2);
        e_sc  = mf[2] & ~mp[2];
        mp = mf;
        for (int b = 0; b < 3; b++) begin
            all_diff = 1;
            for (int k = 0; k < FILT; k++)
                if (hist[(n - SYNC - k) % 64][b] == mf[b]) all_diff = 0;
            if (all_diff) mf[b] = ~mf[b];
        end
        @(negedge Clock);
        tick_no++;
        check("CountEn", qd.CountEn, e_ce);
        check("DownEn",  qd.DownEn,  e_dn);
        check("Error",   qd.Error,   e_err);
        check("SClear",  qd.SClear,  e_sc);
        if (qd.CountEn === 1'b1) begin cnt_ce++; if (first_ce < 0) first_ce = tick_no; end
        if (qd.Error   === 1'b1) cnt_err++;
        if (qd.SClear  === 1'b1) begin cnt_sc++; if (first_sc < 0) first_sc = tick_no; end
    endtask

    task automatic hold(input logic [2:0] p, input int cycles);
        for (int i = 0; i < cycles; i++) tick(p);
    endtask

    task automatic do_reset(input logic [2:0] p);
        Reset = 1'b1;
        drive(p & PMASK);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        model_reset(p & PMASK);
    endtask

    initial begin
        logic [2:0] cur;
        logic [2:0] nxt;
        int r;

        Reset = 1'b1;
        drive(3'b011);
        @(negedge Clock);
        check("rst_CountEn", qd.CountEn, 0);
        check("rst_DownEn",  qd.DownEn,  0);
        check("rst_Error",   qd.Error,   0);
        check("rst_SClear",  qd.SClear,  0);

        // Release with both phases high: no step, no error.
        do_reset(3'b011);
        clr_stats();
        hold(3'b011, 25);
        check("init11_ce",  cnt_ce,  0);
        check("init11_err", cnt_err, 0);

        do_reset(3'b000);
        hold(3'b000, 12);

        // Forward 00,10,11,01,00.
        clr_stats();
        hold(3'b001, 10); hold(3'b011, 10); hold(3'b010, 10); hold(3'b000, 10);
        check("fwd_pulses",  cnt_ce, 4);
        check("fwd_latency", first_ce, 7);
        check("fwd_down",    qd.DownEn, 0);

        // Reverse 00,01,11,10,00 then idle.
        clr_stats();
        hold(3'b010, 10); hold(3'b011, 10); hold(3'b001, 10); hold(3'b000, 10);
        check("rev_pulses", cnt_ce, 4);
        clr_stats();
        hold(3'b000, 20);
        check("rev_idle_pulses", cnt_ce, 0);
        check("rev_idle_down",   qd.DownEn, 1);

        // Glitches on A.
        clr_stats();
        hold(3'b001, FILT - 1); hold(3'b000, 15);
        check("glitch3_ce",  cnt_ce,  0);
        check("glitch3_err", cnt_err, 0);
        clr_stats();
        hold(3'b001, FILT); hold(3'b000, 15);
        check("glitch4_ce", cnt_ce, 2);

        // Both phases together.
        clr_stats();
        hold(3'b011, 10);
        check("both_err", cnt_err, 1);
        check("both_ce",  cnt_ce,  0);
        hold(3'b000, 10);

`ifdef QDEC_INDEX_EN
        clr_stats();
        hold(3'b100, 10); hold(3'b000, 10);
        check("idx_pulses",  cnt_sc, 1);
        check("idx_latency", first_sc, 7);
`endif

        // Reset while a reverse step pulse is high.
        clr_stats();
        for (int i = 0; i < 20 && qd.CountEn !== 1'b1; i++) tick(3'b010);
        check("pre_rst_ce", qd.CountEn, 1);
        #1 Reset = 1'b1;
        #1;
        check("midrst_CountEn", qd.CountEn, 0);
        check("midrst_DownEn",  qd.DownEn,  0);
        check("midrst_Error",   qd.Error,   0);
        check("midrst_SClear",  qd.SClear,  0);
        do_reset(3'b010);
        hold(3'b010, 12);

        // Random walk over steps, double edges, short pulses and index toggles.
        cur = 3'b010;
        for (int s = 0; s < 400; s++) begin
            r = int'($urandom_range(0, 9));
            nxt = cur;
            case (r)
                0, 1, 2, 3: nxt[1:0] = (cur[1:0] == 2'b00) ? 2'b01 : (cur[1:0] == 2'b01) ? 2'b11 :
                                       (cur[1:0] == 2'b11) ? 2'b10 : 2'b00;
                4, 5, 6:    nxt[1:0] = (cur[1:0] == 2'b00) ? 2'b10 : (cur[1:0] == 2'b10) ? 2'b11 :
                                       (cur[1:0] == 2'b11) ? 2'b01 : 2'b00;
                7:          nxt[1:0] = ~cur[1:0];
                8:          nxt[0]   = ~cur[0];
                default:    nxt[2]   = ~cur[2];
            endcase
            if ($urandom_range(0, 5) == 0) nxt[2] = ~nxt[2];
            hold(nxt, int'($urandom_range(1, 12)));
            cur = nxt;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got 0, expected 1");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
